// File: rtl/hazard_stall_unit_if.sv
// Bundle of decode-stage hazard inputs and pipeline control outputs for hazard_stall_unit.
// The optional counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_unit_if #(
    parameter int REGFILE_LEN = 6,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 32
);
    logic [INSTR_WIDTH-1:0] instr_IF_ID;
    logic [REGFILE_LEN-1:0] rs1_IF_ID;
    logic [REGFILE_LEN-1:0] rs2_IF_ID;
    logic [REGFILE_LEN-1:0] rd_ID_EX;
    logic                   mem_read_ID_EX;
    logic                   reg_write_ID_EX;
    logic [REGFILE_LEN-1:0] rd_EX_MEM;
    logic                   mem_read_EX_MEM;
    logic                   redirect_ID;
    logic                   mem_busy;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic stall_active;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_cycles;
    logic [CNT_WIDTH-1:0] freeze_cycles;
`endif

    modport master (
        output instr_IF_ID, rs1_IF_ID, rs2_IF_ID, rd_ID_EX, mem_read_ID_EX,
               reg_write_ID_EX, rd_EX_MEM, mem_read_EX_MEM, redirect_ID, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, stall_active
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cycles, flush_cycles, freeze_cycles
`endif
    );

    modport slave (
        input  instr_IF_ID, rs1_IF_ID, rs2_IF_ID, rd_ID_EX, mem_read_ID_EX,
               reg_write_ID_EX, rd_EX_MEM, mem_read_EX_MEM, redirect_ID, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, stall_active
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cycles, flush_cycles, freeze_cycles
`endif
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use / branch-operand stalls, redirect flush, memory freeze.
// Define HAZARD_PERF_CNT_EN to add stall/flush/freeze cycle counters.
module hazard_stall_unit #(
    parameter int REGFILE_LEN  = 6,
    parameter int INSTR_WIDTH  = 32,
    parameter int OPCODE_WIDTH = 7,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  bus
);
    localparam logic [OPCODE_WIDTH-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
    localparam logic [REGFILE_LEN-1:0]  REG_X0    = '0;

    typedef enum logic [1:0] {IDLE, STALL, FREEZE} state_t;

    state_t      state_q, saved_q, eff_state;
    logic [1:0]  remaining_q;

    logic [INSTR_WIDTH-1:0]  instr;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic use_rs1, use_rs2, is_redirect_op;
    logic hit_ex, hit_mem;
    logic h_lu, h_bl2, h_ba, h_bl1, hazard;
    logic stall_now, redirect_now;

    assign instr  = bus.instr_IF_ID;
    assign opcode = instr[OPCODE_WIDTH-1:0];

    always_comb begin
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        is_redirect_op = 1'b0;
        case (opcode)
            OP_R, OP_STORE:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BRANCH:        begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_redirect_op = 1'b1; end
            OP_IALU, OP_LOAD: use_rs1 = 1'b1;
            OP_JALR:          begin use_rs1 = 1'b1; is_redirect_op = 1'b1; end
            default:          ;
        endcase
    end

    // x0 is hardwired, so a match on index 0 never creates a dependency.
    assign hit_ex  = (use_rs1 && bus.rs1_IF_ID != REG_X0 && bus.rs1_IF_ID == bus.rd_ID_EX)
                  || (use_rs2 && bus.rs2_IF_ID != REG_X0 && bus.rs2_IF_ID == bus.rd_ID_EX);
    assign hit_mem = (use_rs1 && bus.rs1_IF_ID != REG_X0 && bus.rs1_IF_ID == bus.rd_EX_MEM)
                  || (use_rs2 && bus.rs2_IF_ID != REG_X0 && bus.rs2_IF_ID == bus.rd_EX_MEM);

    assign h_lu   = !is_redirect_op && bus.mem_read_ID_EX && hit_ex;
    assign h_bl2  =  is_redirect_op && bus.mem_read_ID_EX && hit_ex;
    assign h_ba   =  is_redirect_op && bus.reg_write_ID_EX && !bus.mem_read_ID_EX && hit_ex;
    assign h_bl1  =  is_redirect_op && bus.mem_read_EX_MEM && hit_mem;
    assign hazard = h_lu || h_bl2 || h_ba || h_bl1;

    // On the cycle memory unblocks, FREEZE behaves exactly like the state it interrupted.
    assign eff_state    = (state_q == FREEZE) ? saved_q : state_q;
    assign stall_now    = !bus.mem_busy && ((eff_state == STALL) || (eff_state == IDLE && hazard));
    assign redirect_now = !bus.mem_busy && !stall_now && bus.redirect_ID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            saved_q     <= IDLE;
            remaining_q <= 2'd0;
        end else if (bus.mem_busy) begin
            state_q <= FREEZE;
            saved_q <= eff_state;
        end else begin
            case (eff_state)
                IDLE: begin
                    if (h_bl2) begin
                        remaining_q <= 2'd1;
                        state_q     <= STALL;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                STALL: begin
                    remaining_q <= (remaining_q == 2'd0) ? 2'd0 : remaining_q - 2'd1;
                    state_q     <= (remaining_q > 2'd1) ? STALL : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic pc_write_d, if_id_write_d, if_id_flush_d, id_ex_write_d, id_ex_flush_d, ex_mem_write_d;

    always_comb begin
        pc_write_d     = 1'b1;
        if_id_write_d  = 1'b1;
        if_id_flush_d  = 1'b0;
        id_ex_write_d  = 1'b1;
        id_ex_flush_d  = 1'b0;
        ex_mem_write_d = 1'b1;
        if (!rst) begin
            if (bus.mem_busy) begin
                pc_write_d     = 1'b0;
                if_id_write_d  = 1'b0;
                id_ex_write_d  = 1'b0;
                ex_mem_write_d = 1'b0;
            end else if (stall_now) begin
                pc_write_d    = 1'b0;
                if_id_write_d = 1'b0;
                id_ex_flush_d = 1'b1;
            end else if (redirect_now) begin
                if_id_flush_d = 1'b1;
            end
        end
    end

    assign bus.pc_write     = pc_write_d;
    assign bus.if_id_write  = if_id_write_d;
    assign bus.if_id_flush  = if_id_flush_d;
    assign bus.id_ex_write  = id_ex_write_d;
    assign bus.id_ex_flush  = id_ex_flush_d;
    assign bus.ex_mem_write = ex_mem_write_d;
    assign bus.stall_active = !rst && (state_q != IDLE);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (id_ex_flush_d) stall_cnt_q  <= stall_cnt_q + 1'b1;
            if (if_id_flush_d) flush_cnt_q  <= flush_cnt_q + 1'b1;
            if (bus.mem_busy)  freeze_cnt_q <= freeze_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cycles  = stall_cnt_q;
    assign bus.flush_cycles  = flush_cnt_q;
    assign bus.freeze_cycles = freeze_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized + directed bench for hazard_stall_unit against a stall-budget reference model.
module tb_hazard_stall_unit;
    localparam logic [6:0] OP_R = 7'b0110011, OP_ST = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_IA = 7'b0010011, OP_LD = 7'b0000011, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.REGFILE_LEN(6), .INSTR_WIDTH(32), .CNT_WIDTH(32)) bus ();

    hazard_stall_unit #(.REGFILE_LEN(6), .INSTR_WIDTH(32), .OPCODE_WIDTH(7), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: committed stall cycles still owed, and whether memory froze us last cycle.
    int owed = 0;
    bit frozen = 1'b0;
    longint n_stall = 0, n_flush = 0, n_freeze = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int need_stalls(input logic [6:0] op, input logic [5:0] r1, r2, rdex,
                                       input bit mrex, rwex, input logic [5:0] rdmem, input bit mrmem);
        bit u1 = 0, u2 = 0, br = 0, hex, hmem;
        case (op)
            OP_R, OP_ST: begin u1 = 1; u2 = 1; end
            OP_BR:       begin u1 = 1; u2 = 1; br = 1; end
            OP_IA, OP_LD: u1 = 1;
            OP_JALR:     begin u1 = 1; br = 1; end
            default: ;
        endcase
        hex  = (u1 && r1 != 0 && r1 == rdex)  || (u2 && r2 != 0 && r2 == rdex);
        hmem = (u1 && r1 != 0 && r1 == rdmem) || (u2 && r2 != 0 && r2 == rdmem);
        if (!br) return (mrex && hex) ? 1 : 0;
        if (mrex && hex) return 2;
        if ((rwex && hex) || (mrmem && hmem)) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] outs_now();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                bus.id_ex_flush, bus.ex_mem_write, bus.stall_active};
    endfunction

    task automatic check_counters();
`ifdef HAZARD_PERF_CNT_EN
        check_eq("stall_cycles",  bus.stall_cycles,  n_stall[31:0]);
        check_eq("flush_cycles",  bus.flush_cycles,  n_flush[31:0]);
        check_eq("freeze_cycles", bus.freeze_cycles, n_freeze[31:0]);
`endif
    endtask

    task automatic drive_idle();
        bus.instr_IF_ID = {25'd0, OP_LUI};
        bus.rs1_IF_ID = 0; bus.rs2_IF_ID = 0; bus.rd_ID_EX = 0; bus.rd_EX_MEM = 0;
        bus.mem_read_ID_EX = 0; bus.reg_write_ID_EX = 0; bus.mem_read_EX_MEM = 0;
        bus.redirect_ID = 0; bus.mem_busy = 0;
    endtask

    task automatic step(input logic [6:0] op, input logic [5:0] r1, r2, rdex, input bit mrex, rwex,
                        input logic [5:0] rdmem, input bit mrmem, busy, redir);
        logic [6:0] exp;
        bit sa;
        int n;
        @(negedge clk);
        bus.instr_IF_ID = {$urandom_range(0, 32'h1ff_ffff), 7'b0} | {25'd0, op};
        bus.rs1_IF_ID = r1; bus.rs2_IF_ID = r2; bus.rd_ID_EX = rdex; bus.rd_EX_MEM = rdmem;
        bus.mem_read_ID_EX = mrex; bus.reg_write_ID_EX = rwex; bus.mem_read_EX_MEM = mrmem;
        bus.mem_busy = busy; bus.redirect_ID = redir;
        #2;
        sa = frozen || (owed > 0);
        if (busy) begin
            exp = {6'b000000, sa};
            frozen = 1'b1;
        end else begin
            frozen = 1'b0;
            n = need_stalls(op, r1, r2, rdex, mrex, rwex, rdmem, mrmem);
            if (owed > 0) begin
                exp = {6'b000111, sa}; owed--;
            end else if (n > 0) begin
                exp = {6'b000111, sa}; owed = n - 1;
            end else if (redir) begin
                exp = {6'b111101, sa};
            end else begin
                exp = {6'b110101, sa};
            end
        end
        check_counters();
        check_eq("outs", {25'd0, outs_now()}, {25'd0, exp});
        $display("cyc %0d op=%b rs=%0d/%0d ex=%0d/%b%b mem=%0d/%b busy=%b redir=%b outs=%b exp=%b",
                 cyc, op, r1, r2, rdex, mrex, rwex, rdmem, mrmem, busy, redir, outs_now(), exp);
        if (exp[2]) n_stall++;
        if (exp[4]) n_flush++;
        if (busy)   n_freeze++;
        cyc++;
    endtask

    // Asserts reset between clock edges and checks the outputs react with no edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_eq("rst_outs", {25'd0, outs_now()}, {25'd0, 7'b1101010});
        owed = 0; frozen = 1'b0; n_stall = 0; n_flush = 0; n_freeze = 0;
        check_counters();
        $display("cyc %0d reset outs=%b", cyc, outs_now());
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{OP_R, OP_ST, OP_BR, OP_IA, OP_LD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL, OP_SYS};
        drive_idle();
        #2;
        check_eq("init_rst_outs", {25'd0, outs_now()}, {25'd0, 7'b1101010});
        check_counters();
        @(negedge clk);
        rst = 1'b0;

        // load-use: lw x5 in EX, add with rs2=5
        step(OP_R, 6'd1, 6'd5, 6'd5, 1, 1, 6'd0, 0, 0, 0);
        step(OP_R, 6'd1, 6'd2, 6'd9, 0, 1, 6'd0, 0, 0, 0);
        // branch after load: two stalls, then idle
        step(OP_BR, 6'd7, 6'd3, 6'd7, 1, 1, 6'd0, 0, 0, 0);
        step(OP_BR, 6'd7, 6'd3, 6'd7, 1, 1, 6'd0, 0, 0, 0);
        step(OP_BR, 6'd7, 6'd3, 6'd9, 0, 0, 6'd7, 0, 0, 0);
        // x0 source and unused sources
        step(OP_R, 6'd0, 6'd0, 6'd0, 1, 1, 6'd0, 0, 0, 0);
        step(OP_LUI, 6'd5, 6'd5, 6'd5, 1, 1, 6'd5, 1, 0, 0);
        // freeze mid-stall
        step(OP_JALR, 6'd4, 6'd0, 6'd4, 1, 1, 6'd0, 0, 0, 0);
        step(OP_R, 6'd1, 6'd2, 6'd3, 0, 0, 6'd0, 0, 1, 0);
        step(OP_R, 6'd1, 6'd2, 6'd3, 0, 0, 6'd0, 0, 1, 0);
        step(OP_R, 6'd1, 6'd2, 6'd3, 0, 0, 6'd0, 0, 1, 0);
        step(OP_R, 6'd1, 6'd2, 6'd3, 0, 0, 6'd0, 0, 0, 1);
        step(OP_R, 6'd1, 6'd2, 6'd3, 0, 0, 6'd0, 0, 0, 0);
        // redirect masked by H_BA, then honoured
        step(OP_BR, 6'd6, 6'd2, 6'd6, 0, 1, 6'd0, 0, 0, 1);
        step(OP_BR, 6'd6, 6'd2, 6'd8, 0, 1, 6'd0, 0, 0, 1);
        // H_BL1 from a load in MEM
        step(OP_BR, 6'd3, 6'd2, 6'd8, 0, 0, 6'd2, 1, 0, 0);
        // reset mid-STALL and mid-FREEZE
        step(OP_BR, 6'd7, 6'd3, 6'd3, 1, 1, 6'd0, 0, 0, 0);
        do_reset();
        step(OP_BR, 6'd7, 6'd3, 6'd3, 1, 1, 6'd0, 0, 0, 0);
        step(OP_R, 6'd1, 6'd2, 6'd3, 0, 0, 6'd0, 0, 1, 0);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) do_reset();
            step(ops[$urandom_range(0, 9)], 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                 6'($urandom_range(0, 7)), ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 50),
                 6'($urandom_range(0, 7)), ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decode-stage hazard controller that pairs with the forwarding unit.
- Detects hazards that forwarding cannot cover:
  - load-use into the EX stage;
  - branch/JALR in IF/ID whose operand comes from a load still in flight.
- Generates pipeline write-enables, bubbles and flushes.
- A small FSM holds multi-cycle stalls. A data-memory busy freeze takes priority over all other actions.

Parameters:
- REGFILE_LEN, 6, register index width.
- INSTR_WIDTH, 32, instruction width.
- OPCODE_WIDTH, 7, opcode field width.
- CNT_WIDTH, 32, performance counter width (optional feature only).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- instr_IF_ID  input  INSTR_WIDTH  instruction in decode.
- rs1_IF_ID  input  REGFILE_LEN  decode source 1.
- rs2_IF_ID  input  REGFILE_LEN  decode source 2.
- rd_ID_EX  input  REGFILE_LEN  destination in EX.
- mem_read_ID_EX  input  1  EX instruction is a load.
- reg_write_ID_EX  input  1  EX instruction writes a register.
- rd_EX_MEM  input  REGFILE_LEN  destination in MEM.
- mem_read_EX_MEM  input  1  MEM instruction is a load.
- redirect_ID  input  1  taken branch or JALR resolved in ID this cycle.
- mem_busy  input  1  data memory not ready.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register enable.
- if_id_flush  output  1  IF/ID becomes NOP.
- id_ex_write  output  1  ID/EX register enable.
- id_ex_flush  output  1  insert bubble into ID/EX.
- ex_mem_write  output  1  EX/MEM and MEM/WB enable.
- stall_active  output  1  FSM not in IDLE.

Behaviour:
Clocking and reset:
- One clock, clk. Reset rst is asynchronous, active-high.
- Reset puts the FSM in IDLE with remaining=0.
- While rst=1, outputs are pc_write=1, if_id_write=1, id_ex_write=1, ex_mem_write=1, if_id_flush=0, id_ex_flush=0, stall_active=0.

Operand-use decode (opcode of instr_IF_ID):
- rs1 and rs2 used: R (0110011), store (0100011), branch (1100011).
- rs1 only: I-ALU (0010011), load (0000011), JALR (1100111).
- Neither: LUI, AUIPC, JAL, other.
- A match against x0 (index 0) is never a hazard.

Hazards (combinational):
- H_LU: mem_read_ID_EX and rd_ID_EX equals a used source, for a non-branch/JALR instruction. Needs 1 stall.
- H_BL2: branch/JALR, mem_read_ID_EX, and rd_ID_EX matches a used source. Needs 2 stalls.
- H_BA: branch/JALR, reg_write_ID_EX with no load, and rd_ID_EX matches a used source. Needs 1 stall.
- H_BL1: branch/JALR, mem_read_EX_MEM, and rd_EX_MEM matches a used source. Needs 1 stall.

FSM states: IDLE, STALL, FREEZE. A 2-bit counter `remaining` tracks outstanding stall cycles.
- IDLE:
  - Any hazard: stall this cycle (pc_write=0, if_id_write=0, id_ex_flush=1).
  - If H_BL2: remaining=1, go to STALL. Otherwise stay in IDLE; the next cycle re-evaluates.
- STALL: stall outputs as above. remaining decrements. At 0, go to IDLE.
- Any state with mem_busy=1:
  - All *_write=0, no flushes. Enter FREEZE and save the prior state.
  - `remaining` is frozen.
  - When mem_busy drops, return to the saved state in the next cycle.
- redirect_ID:
  - Honoured only when no stall and no freeze: if_id_flush=1 for one cycle, pc_write=1.
  - Ignored while stalled; the branch re-resolves after the stall.
- Priority: mem_busy > stall > redirect.
- id_ex_flush and if_id_flush are never both 1.
- stall_active=1 in STALL and FREEZE.
- Reset asserted mid-STALL or mid-FREEZE aborts to IDLE immediately.

Optional Feature:
HAZARD_PERF_CNT_EN defined:
- Adds outputs stall_cycles, flush_cycles and freeze_cycles, each CNT_WIDTH wide.
- Each increments on a clk edge when its condition is active:
  - stall_cycles: id_ex_flush=1.
  - flush_cycles: if_id_flush=1.
  - freeze_cycles: mem_busy=1.
- Counters wrap at 2^CNT_WIDTH and clear on rst.

Not defined: no counters, and those ports are absent.

Test Plan:
- Load-use: lw x5 in EX (mem_read_ID_EX=1, rd_ID_EX=5), add with rs2_IF_ID=5 in ID -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then normal.
- Branch after load: beq rs1=7 with lw x7 in EX -> 2 consecutive stall cycles, stall_active=1 in cycle 2, IDLE on cycle 3.
- x0 and unused source: lw x0 followed by add x1,x0,x0; lui x3 with rs fields equal to 5 while lw x5 is in EX -> no stall in either case.
- Freeze mid-stall: mem_busy=1 for 3 cycles during STALL (remaining=1) -> all writes 0 for 3 cycles, then 1 remaining stall cycle, then IDLE.
- Redirect masking: redirect_ID=1 together with H_BA -> stall only, if_id_flush=0. The next cycle with redirect_ID=1 and no hazard gives if_id_flush=1 and id_ex_flush=0.
- Reset mid-STALL: assert rst during STALL -> outputs immediately return to their reset values, with no clk edge needed.
